// File: rtl/adsr_envelope_mc.sv
// Multi-channel ADSR envelope generator: per-channel tick-driven state machines feeding one shared
// 3-stage interpolation pipeline, one channel per clock. Define ENV_RETRIGGER_EN for legato retrigger.
module adsr_envelope_mc #(
  parameter int CHANNELS = 4,
  parameter int LEVEL_W  = 12,
  parameter int TIME_W   = 24
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        tick,
  input  logic [CHANNELS-1:0]         note_on,
  input  logic [CHANNELS-1:0]         note_off,
  input  logic [LEVEL_W-1:0]          lvl_a,
  input  logic [LEVEL_W-1:0]          lvl_b,
  input  logic [LEVEL_W-1:0]          lvl_c,
  input  logic [LEVEL_W-1:0]          lvl_d,
  input  logic [TIME_W-1:0]           dur_x,
  input  logic [TIME_W-1:0]           dur_y,
  input  logic [TIME_W-1:0]           dur_z,
  output logic [CHANNELS-1:0]         busy,
  output logic [CHANNELS-1:0]         done,
  output logic                        out_valid,
  output logic [$clog2(CHANNELS)-1:0] out_ch,
  output logic [LEVEL_W-1:0]          out_level
);

  localparam int CH_W = $clog2(CHANNELS);
  localparam int IW   = LEVEL_W + TIME_W + 2;

  typedef enum logic [2:0] {S_IDLE, S_ATTACK, S_DECAY, S_SUSTAIN, S_RELEASE} state_t;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [TIME_W-1:0]   cnt_q   [CHANNELS];
  logic [TIME_W-1:0]   cnt_d   [CHANNELS];
  logic [LEVEL_W-1:0]  start_q [CHANNELS];
  logic [LEVEL_W-1:0]  start_d [CHANNELS];
  logic [LEVEL_W-1:0]  last_q  [CHANNELS];
  logic [CHANNELS-1:0] on_p, off_p, on_e, off_e;
  logic [CHANNELS-1:0] done_d, done_q;
  logic [CH_W-1:0]     slot;

  logic [LEVEL_W-1:0]     s_sel, e_sel;
  logic [TIME_W-1:0]      n_sel, d_sel;
  logic                   vld_p0, vld_p1;
  logic [LEVEL_W-1:0]     s_p0, e_p0, s_p1, e_p1;
  logic [TIME_W-1:0]      n_p0, d_p0, d_p1;
  logic [CH_W-1:0]        ch_p0, ch_p1;
  logic signed [IW-1:0]   prod_p1;
  logic [LEVEL_W-1:0]     level_p1;

  function automatic logic expired(input logic [TIME_W-1:0] n, input logic [TIME_W-1:0] d);
    return ({1'b0, n} + (TIME_W+1)'(1)) >= {1'b0, d};
  endfunction

  function automatic logic signed [IW-1:0] interp_prod(input logic [LEVEL_W-1:0] s,
                                                       input logic [LEVEL_W-1:0] e,
                                                       input logic [TIME_W-1:0]  n);
    return ($signed(IW'(e)) - $signed(IW'(s))) * $signed(IW'(n));
  endfunction

  // Signed division truncates toward zero; a zero duration jumps straight to the end level.
  function automatic logic [LEVEL_W-1:0] interp_finish(input logic signed [IW-1:0] prod,
                                                       input logic [LEVEL_W-1:0]  s,
                                                       input logic [LEVEL_W-1:0]  e,
                                                       input logic [TIME_W-1:0]   d);
    logic [LEVEL_W-1:0] r;
    if (d == '0) r = e;
    else         r = LEVEL_W'($signed(IW'(s)) + prod / $signed(IW'(d)));
    return r;
  endfunction

  // Pulses arriving with tick are evaluated on that same tick.
  assign on_e  = on_p | note_on;
  assign off_e = off_p | note_off;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= S_IDLE;
        cnt_q[c]   <= '0;
        start_q[c] <= '0;
      end
      on_p   <= '0;
      off_p  <= '0;
      done_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        start_q[c] <= start_d[c];
      end
      done_q <= done_d;
      if (tick) begin
        on_p  <= '0;
        off_p <= '0;
      end else begin
        on_p  <= on_p | note_on;
        off_p <= off_p | note_off;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      start_d[c] = start_q[c];
      done_d[c]  = 1'b0;
      if (tick) begin
        case (state_q[c])
          S_IDLE: begin
            if (on_e[c]) begin
              state_d[c] = S_ATTACK;
              cnt_d[c]   = '0;
              start_d[c] = lvl_a;
            end
          end
          S_ATTACK, S_DECAY: begin
            if (off_e[c]) begin
              state_d[c] = S_RELEASE;
              cnt_d[c]   = '0;
              start_d[c] = last_q[c];
            end
`ifdef ENV_RETRIGGER_EN
            else if (on_e[c]) begin
              state_d[c] = S_ATTACK;
              cnt_d[c]   = '0;
              start_d[c] = last_q[c];
            end
`endif
            else if (expired(cnt_q[c], (state_q[c] == S_ATTACK) ? dur_x : dur_y)) begin
              state_d[c] = (state_q[c] == S_ATTACK) ? S_DECAY : S_SUSTAIN;
              cnt_d[c]   = '0;
            end else begin
              cnt_d[c] = cnt_q[c] + TIME_W'(1);
            end
          end
          S_SUSTAIN: begin
            if (off_e[c]) begin
              state_d[c] = S_RELEASE;
              cnt_d[c]   = '0;
              start_d[c] = last_q[c];
            end
`ifdef ENV_RETRIGGER_EN
            else if (on_e[c]) begin
              state_d[c] = S_ATTACK;
              cnt_d[c]   = '0;
              start_d[c] = last_q[c];
            end
`endif
          end
          S_RELEASE: begin
`ifdef ENV_RETRIGGER_EN
            if (on_e[c] && !off_e[c]) begin
              state_d[c] = S_ATTACK;
              cnt_d[c]   = '0;
              start_d[c] = last_q[c];
            end else
`endif
            if (expired(cnt_q[c], dur_z)) begin
              state_d[c] = S_IDLE;
              cnt_d[c]   = '0;
              done_d[c]  = 1'b1;
            end else begin
              cnt_d[c] = cnt_q[c] + TIME_W'(1);
            end
          end
          default: state_d[c] = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) busy[c] = (state_q[c] != S_IDLE);
  end

  assign done = done_q;

  // Stage p0: pick interpolation endpoints for the channel in the current slot.
  always_comb begin
    s_sel = lvl_a;
    e_sel = lvl_a;
    n_sel = '0;
    d_sel = '0;
    case (state_q[slot])
      S_ATTACK:  begin s_sel = start_q[slot]; e_sel = lvl_b; n_sel = cnt_q[slot]; d_sel = dur_x; end
      S_DECAY:   begin s_sel = lvl_b;         e_sel = lvl_c; n_sel = cnt_q[slot]; d_sel = dur_y; end
      S_SUSTAIN: begin s_sel = lvl_c;         e_sel = lvl_c; end
      S_RELEASE: begin s_sel = start_q[slot]; e_sel = lvl_d; n_sel = cnt_q[slot]; d_sel = dur_z; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      slot   <= '0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      slot   <= (slot == CH_W'(CHANNELS - 1)) ? '0 : slot + CH_W'(1);
      vld_p0 <= 1'b1;
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    s_p0  <= s_sel;
    e_p0  <= e_sel;
    n_p0  <= n_sel;
    d_p0  <= d_sel;
    ch_p0 <= slot;
    // Stage p1: product of the level span and elapsed count.
    prod_p1 <= interp_prod(s_p0, e_p0, n_p0);
    s_p1    <= s_p0;
    e_p1    <= e_p0;
    d_p1    <= d_p0;
    ch_p1   <= ch_p0;
  end

  // Stage p2: divide, offset, publish and remember the level for release/retrigger starts.
  assign level_p1 = interp_finish(prod_p1, s_p1, e_p1, d_p1);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_level <= '0;
      for (int c = 0; c < CHANNELS; c++) last_q[c] <= '0;
    end else begin
      out_valid <= vld_p1;
      out_ch    <= ch_p1;
      out_level <= level_p1;
      if (vld_p1) last_q[ch_p1] <= level_p1;
    end
  end

endmodule
